// File: rtl/seg_display_counter_n.sv
// N-digit hex up/down counter with debounced button, auto-tick and a
// multiplexed, optionally leading-zero-blanked seven-segment display.

module seg_digit_lane #(
   parameter bit IS_LSD   = 1'b0,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic [3:0] i_nib,
   input  logic       i_hi_zero,
   output logic [6:0] o_seg
);
   always_comb begin
      o_seg = 7'b1111111;
      case (i_nib)
         4'h0: o_seg = 7'b1000000;
         4'h1: o_seg = 7'b1111001;
         4'h2: o_seg = 7'b0100100;
         4'h3: o_seg = 7'b0110000;
         4'h4: o_seg = 7'b0011001;
         4'h5: o_seg = 7'b0010010;
         4'h6: o_seg = 7'b0000010;
         4'h7: o_seg = 7'b1111000;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0010000;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b0000011;
         4'hC: o_seg = 7'b1000110;
         4'hD: o_seg = 7'b0100001;
         4'hE: o_seg = 7'b0000110;
         4'hF: o_seg = 7'b0001110;
         default: o_seg = 7'b1111111;
      endcase
      // the least-significant digit always shows, even when the count is zero
      if (BLANK_LZ && !IS_LSD && i_hi_zero) o_seg = 7'b1111111;
   end
endmodule

module seg_display_counter_n #(
   parameter int DIGITS          = 4,
   parameter int REFRESH_DIV     = 50000,
   parameter int TICK_DIV        = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BLANK_LZ        = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_button,
   input  logic                  i_mode,
   input  logic                  i_up_down,
   input  logic                  i_clear,
   output logic [4*DIGITS-1:0]   o_count,
   output logic [DIGITS-1:0]     o_an,
   output logic [6:0]            o_seven
);
   localparam int W  = 4*DIGITS;
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [1:0]             r_sync;
   logic                   r_db, r_db_q;
   logic [DW-1:0]          r_db_cnt;
   logic [TW-1:0]          r_tick_cnt;
   logic [RW-1:0]          r_ref_cnt;
   logic [IW-1:0]          r_idx;
   logic [W-1:0]           r_count;
   logic [DIGITS-1:0]      r_an;
   logic [6:0]             r_seven;

   logic                   w_press, w_tick, w_step, w_ref_wrap;
   logic [DIGITS-1:0][6:0] w_lane_seg;

   // debounced level only moves after DEBOUNCE_CYCLES consecutive disagreements
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync   <= '0;
         r_db     <= 1'b0;
         r_db_q   <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync <= {r_sync[0], i_button};
         r_db_q <= r_db;
         if (r_sync[1] != r_db) begin
            if (r_db_cnt == DW'(DEBOUNCE_CYCLES-1)) begin
               r_db     <= r_sync[1];
               r_db_cnt <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + DW'(1);
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   assign w_press    = r_db & ~r_db_q;
   assign w_tick     = (r_tick_cnt == TW'(TICK_DIV-1));
   assign w_step     = i_mode ? w_tick : w_press;
   assign w_ref_wrap = (r_ref_cnt == RW'(REFRESH_DIV-1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tick_cnt <= '0;
         r_count    <= '0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
         if (i_clear)     r_count <= '0;
         else if (w_step) r_count <= i_up_down ? r_count - W'(1) : r_count + W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ref_cnt <= '0;
         r_idx     <= '0;
      end else begin
         r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + RW'(1);
         if (w_ref_wrap) r_idx <= (r_idx == IW'(DIGITS-1)) ? '0 : r_idx + IW'(1);
      end
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lane
      logic w_hi_zero;
      assign w_hi_zero = (r_count[W-1:4*gi] == '0);
      seg_digit_lane #(.IS_LSD(gi == 0), .BLANK_LZ(BLANK_LZ)) u_lane (
         .i_nib     (r_count[4*gi +: 4]),
         .i_hi_zero (w_hi_zero),
         .o_seg     (w_lane_seg[gi])
      );
   end

   // outputs lag the scan index by one cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_an    <= ~DIGITS'(1);
         r_seven <= 7'b1000000;
      end else begin
         r_an    <= ~(DIGITS'(1) << r_idx);
         r_seven <= w_lane_seg[r_idx];
      end
   end

   assign o_count = r_count;
   assign o_an    = r_an;
   assign o_seven = r_seven;
endmodule
